// File: rtl/checker_read_burst_if.sv
// ============================================================================
// checker_read_burst_if : mode-controller and hm page-fetcher signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface checker_read_burst_if #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 8
);
   logic              mode_start;
   logic [ADDR_W-1:0] mode_addr;
   logic [CNT_W-1:0]  mode_count;
   logic              mode_end;
   logic              mode_error;
   logic [ADDR_W-1:0] mode_data;
   logic [CNT_W-1:0]  mode_pages;
   logic              mode_irq;
   logic              mode_ack;
   logic [ADDR_W-1:0] hm_page_addr;
   logic              hm_start;
   logic              hm_end;
   logic              hm_timeout;
   logic              hm_error;

   // Burst engine side
   modport slave (
      input  mode_start, mode_addr, mode_count, mode_ack,
      input  hm_end, hm_timeout, hm_error,
      output mode_end, mode_error, mode_data, mode_pages, mode_irq,
      output hm_page_addr, hm_start
   );

   // Mode controller / page fetcher side
   modport master (
      output mode_start, mode_addr, mode_count, mode_ack,
      output hm_end, hm_timeout, hm_error,
      input  mode_end, mode_error, mode_data, mode_pages, mode_irq,
      input  hm_page_addr, hm_start
   );
endinterface

`default_nettype wire

// File: rtl/checker_read_burst.sv
// ============================================================================
// checker_read_burst : multi-page hm read engine with timeout retry and irq
// Rev 1.0
// ============================================================================
`default_nettype none

module checker_read_burst #(
   parameter int ADDR_W     = 64,
   parameter int PAGE_SHIFT = 12,
   parameter int CNT_W      = 8,
   parameter int RETRIES    = 2
) (
   input  wire logic              sys_clk,
   input  wire logic              sys_rst,
   checker_read_burst_if.slave    bus
);

   localparam int RETRY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(RETRIES);
   localparam logic [ADDR_W-1:0]  ONE         = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0]  PAGE_STRIDE = ONE << PAGE_SHIFT;
   localparam logic [ADDR_W-1:0]  PAGE_MASK   = PAGE_STRIDE - ONE;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_GAP  = 3'd2,
      S_DONE = 3'd3,
      S_FAIL = 3'd4
   } state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   addr, addr_nx;
   logic [CNT_W-1:0]    remaining, remaining_nx;
   logic [CNT_W-1:0]    pages, pages_nx;
   logic [RETRY_W-1:0]  retry, retry_nx;
   logic                hm_start, mode_end, mode_error, irq;
   logic                finishing;

   always_comb begin
      state_nx     = state;
      addr_nx      = addr;
      remaining_nx = remaining;
      pages_nx     = pages;
      retry_nx     = retry;
      case (state)
         S_IDLE: begin
            if (bus.mode_start) begin
               pages_nx = '0;
               if (bus.mode_count != '0) begin
                  addr_nx      = bus.mode_addr & ~PAGE_MASK;
                  remaining_nx = bus.mode_count;
                  retry_nx     = '0;
                  state_nx     = S_WAIT;
               end else begin
                  state_nx = S_DONE;
               end
            end
         end
         S_WAIT: begin
            // hm responses outrank an abort request in the same cycle
            if (bus.hm_error) begin
               state_nx = S_FAIL;
            end else if (bus.hm_end) begin
               pages_nx     = pages + 1'b1;
               remaining_nx = remaining - 1'b1;
               if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  state_nx = S_DONE;
               end else begin
                  addr_nx  = addr + PAGE_STRIDE;
                  retry_nx = '0;
                  state_nx = S_GAP;
               end
            end else if (bus.hm_timeout) begin
               if (retry < RETRY_MAX) begin
                  retry_nx = retry + 1'b1;
                  state_nx = S_GAP;
               end else begin
                  state_nx = S_FAIL;
               end
            end else if (!bus.mode_start) begin
               state_nx = S_IDLE;
            end
         end
         S_GAP:   state_nx = bus.mode_start ? S_WAIT : S_IDLE;
         S_DONE,
         S_FAIL:  if (!bus.mode_start) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign finishing = ((state_nx == S_DONE) || (state_nx == S_FAIL)) &&
                      !((state == S_DONE) || (state == S_FAIL));

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state      <= S_IDLE;
         addr       <= '0;
         remaining  <= '0;
         pages      <= '0;
         retry      <= '0;
         hm_start   <= 1'b0;
         mode_end   <= 1'b0;
         mode_error <= 1'b0;
         irq        <= 1'b0;
      end else begin
         state      <= state_nx;
         addr       <= addr_nx;
         remaining  <= remaining_nx;
         pages      <= pages_nx;
         retry      <= retry_nx;
         hm_start   <= (state_nx == S_WAIT);
         mode_end   <= (state_nx == S_DONE);
         mode_error <= (state_nx == S_FAIL);
         if (finishing) begin
            irq <= 1'b1;
         end else if (bus.mode_ack) begin
            irq <= 1'b0;
         end
      end
   end

   assign bus.hm_start     = hm_start;
   assign bus.hm_page_addr = addr;
   assign bus.mode_data    = addr;
   assign bus.mode_pages   = pages;
   assign bus.mode_end     = mode_end;
   assign bus.mode_error   = mode_error;
   assign bus.mode_irq     = irq;

endmodule

`default_nettype wire

// File: tb/tb_checker_read_burst.sv
// ============================================================================
// tb_checker_read_burst : table, directed and random checks of checker_read_burst
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_checker_read_burst;

   localparam int PAGE_SHIFT = 12;
   localparam int RETRIES    = 2;
   localparam logic [63:0] PAGE_BYTES = 64'd1 << PAGE_SHIFT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   checker_read_burst_if #(.ADDR_W(64), .CNT_W(8)) bus ();

   checker_read_burst #(
      .ADDR_W(64), .PAGE_SHIFT(PAGE_SHIFT), .CNT_W(8), .RETRIES(RETRIES)
   ) dut (
      .sys_clk(clk),
      .sys_rst(rst_n),
      .bus(bus)
   );

   logic        st = 1'b0, ak = 1'b0, he = 1'b0, ht = 1'b0, hr = 1'b0;
   logic [63:0] ad = '0;
   logic [7:0]  cn = '0;

   assign bus.mode_start = st;
   assign bus.mode_addr  = ad;
   assign bus.mode_count = cn;
   assign bus.mode_ack   = ak;
   assign bus.hm_end     = he;
   assign bus.hm_timeout = ht;
   assign bus.hm_error   = hr;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: a run is "page k of total from base", finished with an outcome.
   bit          m_busy, m_gap, m_irq;
   int          m_outcome;   // 0 running/idle, 1 completed, 2 failed
   int          m_tries;
   logic [7:0]  m_pages, m_total;
   logic [63:0] m_base, m_addr;

   task automatic model_reset();
      m_busy = 0; m_gap = 0; m_irq = 0; m_outcome = 0; m_tries = 0;
      m_pages = '0; m_total = '0; m_base = '0; m_addr = '0;
   endtask

   task automatic model_step();
      bit set_irq = 0;
      if (m_outcome != 0) begin
         if (!st) m_outcome = 0;
      end else if (!m_busy) begin
         if (st) begin
            m_pages = '0;
            if (cn == 0) begin
               m_outcome = 1; set_irq = 1;
            end else begin
               m_busy = 1; m_gap = 0; m_tries = 0; m_total = cn;
               m_base = ad & ~(PAGE_BYTES - 64'd1);
               m_addr = m_base;
            end
         end
      end else if (m_gap) begin
         if (st) m_gap = 0; else m_busy = 0;
      end else begin
         if (hr) begin
            m_busy = 0; m_outcome = 2; set_irq = 1;
         end else if (he) begin
            m_pages = m_pages + 8'd1;
            if (m_pages == m_total) begin
               m_busy = 0; m_outcome = 1; set_irq = 1;
            end else begin
               m_tries = 0; m_gap = 1;
               m_addr = m_base + (64'(m_pages) << PAGE_SHIFT);
            end
         end else if (ht) begin
            if (m_tries < RETRIES) begin
               m_tries++; m_gap = 1;
            end else begin
               m_busy = 0; m_outcome = 2; set_irq = 1;
            end
         end else if (!st) begin
            m_busy = 0;
         end
      end
      if (set_irq) m_irq = 1;
      else if (ak) m_irq = 0;
   endtask

   function automatic logic [139:0] dut_outs();
      return {bus.hm_start, bus.mode_end, bus.mode_error, bus.mode_irq,
              bus.mode_pages, bus.mode_data, bus.hm_page_addr};
   endfunction

   function automatic logic [139:0] model_outs();
      return {m_busy && !m_gap && (m_outcome == 0), m_outcome == 1, m_outcome == 2,
              m_irq, m_pages, m_addr, m_addr};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   task automatic chk_model(input string name);
      logic [139:0] g, e;
      g = dut_outs();
      e = model_outs();
      n_vec++;
      if (g !== e) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, g, e);
      end
   endtask

   task automatic tick(input string name);
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      chk_model(name);
      ak = 0; he = 0; ht = 0; hr = 0;
   endtask

   typedef struct {
      logic        start;
      logic [63:0] addr;
      logic [7:0]  count;
      logic        ack, hend, hto, herr;
      logic        x_hs, x_end, x_err, x_irq;
      logic [7:0]  x_pages;
      logic [63:0] x_data;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic [7:0] c, input logic a,
                               input logic e, input logic xh, input logic xe,
                               input logic xi, input logic [7:0] xp, input logic [63:0] xd);
      vec_t v;
      v.start = s; v.addr = 64'h1000; v.count = c; v.ack = a; v.hend = e;
      v.hto = 0; v.herr = 0; v.x_hs = xh; v.x_end = xe; v.x_err = 0; v.x_irq = xi;
      v.x_pages = xp; v.x_data = xd;
      return v;
   endfunction

   vec_t tbl [10];

   initial begin
      model_reset();
      // burst of three pages from 0x1000
      tbl[0] = mk(1, 3, 0, 0, 1, 0, 0, 0, 64'h1000);
      tbl[1] = mk(1, 3, 0, 0, 1, 0, 0, 0, 64'h1000);
      tbl[2] = mk(1, 3, 0, 1, 0, 0, 0, 1, 64'h2000);
      tbl[3] = mk(1, 3, 0, 0, 1, 0, 0, 1, 64'h2000);
      tbl[4] = mk(1, 3, 0, 1, 0, 0, 0, 2, 64'h3000);
      tbl[5] = mk(1, 3, 0, 0, 1, 0, 0, 2, 64'h3000);
      tbl[6] = mk(1, 3, 0, 1, 0, 1, 1, 3, 64'h3000);
      tbl[7] = mk(1, 3, 1, 0, 0, 1, 0, 3, 64'h3000);
      tbl[8] = mk(0, 3, 0, 0, 0, 0, 0, 3, 64'h3000);
      tbl[9] = mk(0, 3, 0, 1, 0, 0, 0, 3, 64'h3000);

      repeat (3) @(posedge clk);
      #1;
      chk_model("reset_state");
      chk("reset_outs", {60'd0, dut_outs() == '0}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         st = tbl[i].start; ad = tbl[i].addr; cn = tbl[i].count; ak = tbl[i].ack;
         he = tbl[i].hend; ht = tbl[i].hto; hr = tbl[i].herr;
         tick("table_model");
         chk($sformatf("table_row%0d", i),
             {{52{1'b0}}, bus.hm_start, bus.mode_end, bus.mode_error, bus.mode_irq, bus.mode_pages},
             {{52{1'b0}}, tbl[i].x_hs, tbl[i].x_end, tbl[i].x_err, tbl[i].x_irq, tbl[i].x_pages});
         chk($sformatf("table_data%0d", i), bus.mode_data, tbl[i].x_data);
      end

      // single page, late completion
      st = 1; ad = 64'h1234; cn = 1;
      tick("single");
      chk("single_hs", {63'd0, bus.hm_start}, 64'd1);
      chk("single_addr", bus.hm_page_addr, 64'h1000);
      repeat (19) tick("single");
      he = 1; tick("single");
      chk("single_end", {62'd0, bus.mode_end, bus.mode_irq}, 64'd3);
      chk("single_pages", {56'd0, bus.mode_pages}, 64'd1);
      ak = 1; tick("single");
      chk("single_ack", {63'd0, bus.mode_irq}, 64'd0);
      st = 0; tick("single");

      // retries exhausted
      st = 1; ad = 64'h1000; cn = 1;
      tick("retry");
      for (int i = 0; i < 2; i++) begin
         ht = 1; tick("retry");
         chk("retry_gap", {63'd0, bus.hm_start}, 64'd0);
         tick("retry");
         chk("retry_reissue", bus.hm_page_addr, 64'h1000);
      end
      ht = 1; tick("retry");
      chk("retry_fail", {62'd0, bus.mode_error, bus.mode_irq}, 64'd3);
      chk("retry_data", bus.mode_data, 64'h1000);
      st = 0; ak = 1; tick("retry");

      // two timeouts then success
      st = 1;
      tick("retry_ok");
      repeat (2) begin
         ht = 1; tick("retry_ok");
         tick("retry_ok");
      end
      he = 1; tick("retry_ok");
      chk("retry_ok_end", {62'd0, bus.mode_end, bus.mode_error}, 64'd2);
      st = 0; ak = 1; tick("retry_ok");

      // error beats end on page 2 of 3
      st = 1; ad = 64'h1000; cn = 3;
      tick("prio");
      he = 1; tick("prio");
      tick("prio");
      he = 1; hr = 1; tick("prio");
      chk("prio_err", {62'd0, bus.mode_error, bus.mode_end}, 64'd2);
      chk("prio_pages", {56'd0, bus.mode_pages}, 64'd1);
      chk("prio_data", bus.mode_data, 64'h2000);
      st = 0; ak = 1; tick("prio");

      // abort after 20 WAIT cycles, then a normal run
      st = 1; cn = 4;
      tick("abort");
      repeat (19) tick("abort");
      st = 0; tick("abort");
      chk("abort_outs", {60'd0, bus.hm_start, bus.mode_end, bus.mode_error, bus.mode_irq}, 64'd0);
      st = 1; ad = 64'h5000; cn = 1;
      tick("after_abort");
      he = 1; tick("after_abort");
      chk("after_abort_end", {63'd0, bus.mode_end}, 64'd1);
      chk("after_abort_data", bus.mode_data, 64'h5000);
      st = 0; ak = 1; tick("after_abort");

      // wrap past the top, then async reset mid-WAIT
      st = 1; ad = 64'hFFFF_FFFF_FFFF_F000; cn = 2;
      tick("wrap");
      chk("wrap_first", bus.hm_page_addr, 64'hFFFF_FFFF_FFFF_F000);
      he = 1; tick("wrap");
      chk("wrap_gap_data", bus.mode_data, 64'h0);
      tick("wrap");
      chk("wrap_second", {63'd0, bus.hm_start}, 64'd1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset", {60'd0, dut_outs() == '0}, 64'd1);
      st = 0;
      @(negedge clk);
      rst_n = 1'b1;
      tick("post_reset");

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         int r;
         if (!st) st = ($urandom_range(0, 2) == 0);
         else if (m_outcome != 0) st = ($urandom_range(0, 1) == 0);
         else st = ($urandom_range(0, 39) != 0);
         ad = {$urandom, $urandom};
         cn = 8'($urandom_range(0, 5));
         ak = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 11);
         he = (r == 0) || (r == 3) || (r == 4);
         ht = (r == 1) || (r == 4);
         hr = (r == 2) || (r == 3);
         tick("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/checker_read_burst.md
# checker_read_burst

Multi-page successor to the single-page checker read engine. On a mode-layer start it walks a run of consecutive pages, issuing one request per page to the host-memory (hm) fetch engine. It retries timed-out pages a bounded number of times and reports completion or failure with a sticky, acknowledgeable interrupt. It sits between the checker mode controller and the hm page fetcher.

## Interface
- ADDR_W, 64, width of mode_addr, hm_page_addr, mode_data
- PAGE_SHIFT, 12, log2 page size; address stride = 2^PAGE_SHIFT
- CNT_W, 8, width of the page count and done count
- RETRIES, 2, extra attempts per page after hm_timeout (0 = no retry)

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-low
- mode_start  in  1  level request; held until mode_end or mode_error
- mode_addr  in  ADDR_W  start address, low PAGE_SHIFT bits ignored
- mode_count  in  CNT_W  number of pages to read
- mode_end  out  1  run completed, held in DONE
- mode_error  out  1  run failed, held in FAIL
- mode_data  out  ADDR_W  last issued page address (failing page in FAIL)
- mode_pages  out  CNT_W  pages completed successfully in this run
- mode_irq  out  1  sticky completion/failure interrupt
- mode_ack  in  1  clears mode_irq
- hm_page_addr  out  ADDR_W  page address to fetch
- hm_start  out  1  request, high for the whole outstanding fetch
- hm_end  in  1  fetch completed, one-cycle pulse
- hm_timeout  in  1  fetch timed out, one-cycle pulse
- hm_error  in  1  fetch failed, one-cycle pulse

## Operation
- States: IDLE, WAIT, GAP, DONE, FAIL.
- IDLE:
  - Sample mode_start. If high and mode_count≠0, latch base = mode_addr with low PAGE_SHIFT bits cleared.
  - Load remaining = mode_count, clear mode_pages and the retry counter, then go to WAIT.
  - If high and mode_count=0, go straight to DONE with no hm_start.
- WAIT: hm_start=1, hm_page_addr = current address. Response priority is hm_error > hm_end > hm_timeout.
  - hm_error: go to FAIL.
  - hm_end: increment mode_pages and decrement remaining. If remaining becomes 0, go to DONE. Otherwise add 2^PAGE_SHIFT to the address, clear the retry counter, and go to GAP.
  - hm_timeout: if retry counter < RETRIES, increment it and go to GAP, keeping the same address. Otherwise go to FAIL.
  - mode_start low with no hm response: abort to IDLE. No mode_end, mode_error or irq. mode_pages is kept.
- GAP: one cycle with hm_start=0, then WAIT. mode_start low here also aborts to IDLE.
- DONE: mode_end=1. FAIL: mode_error=1. Both are held until mode_start is sampled low, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W. Wrap past the top of the address space is silent.
- mode_data always equals hm_page_addr (the current/last page address).
- mode_irq:
  - Set on the cycle of entry to DONE or FAIL.
  - Cleared when mode_ack is sampled high.
  - Simultaneous set and ack: set wins.
  - Independent of mode_start.
- Reset (sys_rst low, asynchronous): state IDLE. All outputs are 0: mode_end, mode_error, mode_data, mode_pages, mode_irq, hm_page_addr, hm_start. Internal counters clear. A reset in the middle of a run drops hm_start immediately.

## Timing
- All outputs are registered.
- mode_start sampled high in IDLE at edge N → hm_start=1 and hm_page_addr valid after edge N (1-cycle latency).
- hm_end sampled at edge M with pages remaining → hm_start=0 for cycle M..M+1, then high again with the next address after M+1.
- Last hm_end (or the deciding hm_error/timeout) sampled at edge M → mode_end/mode_error and mode_irq high after edge M.
- Abort: mode_start sampled low at edge M in WAIT/GAP → hm_start low after edge M.
- hm_* inputs are ignored outside WAIT.
- Back-to-back runs need mode_start low for at least one sampled cycle after DONE/FAIL.

## Test plan
- Single page: mode_addr=0x1234, mode_count=1, hm_end after 20 cycles → hm_page_addr=0x1000, hm_start 1 cycle after start, mode_end and mode_irq the cycle after hm_end, mode_pages=1. mode_ack clears irq.
- Burst: mode_addr=0x1000, mode_count=3, hm_end after each request → addresses 0x1000, 0x2000, 0x3000, one-cycle hm_start gap between them, mode_pages=3, mode_data=0x3000.
- Retry: RETRIES=2, mode_count=1, three hm_timeout pulses → same address reissued twice, then mode_error with mode_data=0x1000 and mode_irq=1. With two timeouts then hm_end → mode_end.
- Error and priority: hm_error together with hm_end on page 2 of 3 → FAIL, mode_pages=1, mode_data=0x2000.
- Abort: mode_start dropped after 20 cycles of WAIT → hm_start low next cycle, no mode_end, mode_error or irq. A following start runs normally.
- Wrap and reset: mode_addr=0xFFFF_FFFF_FFFF_F000, mode_count=2 → second address 0x0. sys_rst asserted mid-WAIT → all outputs 0 immediately.
